// File: rtl/summ_sa_sched.sv
// summ_sa_sched: per-point read, accumulate and handshake sequencer for the summ_sa delay-and-sum accumulator
module summ_sa_sched #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_POINTS   = 64,
    parameter int RD_LAT       = 2,
    parameter int TIMEOUT      = 15,
    parameter int SUM_WIDTH    = DATA_WIDTH + $clog2(NUM_CHANNELS),
    localparam int CW = $clog2(NUM_CHANNELS),
    localparam int PW = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic                  abort,
    output logic                  rd_en,
    output logic [CW-1:0]         rd_ch,
    output logic [PW-1:0]         rd_point,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  start_sum,
    output logic                  sum_en,
    output logic [DATA_WIDTH-1:0] delayed_sample,
    output logic                  done_channel,
    input  logic [SUM_WIDTH-1:0]  sum_result,
    input  logic                  sum_valid,
    output logic [SUM_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);
    typedef enum logic [2:0] {IDLE, START, ISSUE, DRAIN, CLOSE, WAIT_RES, OUTPUT} state_t;

    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);
    localparam logic [PW-1:0] LAST_PT = PW'(NUM_POINTS - 1);
    localparam logic [TW-1:0] LAST_T  = TW'(TIMEOUT - 1);

    state_t state, state_nxt;
    logic [RD_LAT-1:0] vld;
    logic [CW-1:0] se_cnt;
    logic [TW-1:0] tcnt;
    logic timeout, accept, launch;

    // rd_point doubles as the point counter; abort suppresses every exit event
    assign timeout = !abort && state == WAIT_RES && !sum_valid && tcnt == LAST_T;
    assign accept  = !abort && state == OUTPUT && out_ready;
    assign launch  = !abort && state == IDLE && frame_start;

    // next-state decode; abort overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = frame_start ? START : IDLE;
            START:    state_nxt = ISSUE;
            ISSUE:    state_nxt = rd_ch == LAST_CH ? DRAIN : ISSUE;
            DRAIN:    state_nxt = sum_en && se_cnt == LAST_CH ? CLOSE : DRAIN;
            CLOSE:    state_nxt = WAIT_RES;
            WAIT_RES: state_nxt = sum_valid ? OUTPUT : tcnt == LAST_T ? IDLE : WAIT_RES;
            OUTPUT:   state_nxt = !out_ready ? OUTPUT : rd_point == LAST_PT ? IDLE : START;
            default:  state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    // read-return pipeline and per-point counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld            <= '0;
            sum_en         <= 1'b0;
            delayed_sample <= '0;
            se_cnt         <= '0;
            tcnt           <= '0;
            rd_ch          <= '0;
            rd_point       <= '0;
        end else begin
            vld            <= abort ? '0 : RD_LAT'({vld, rd_en});
            sum_en         <= vld[RD_LAT-1] && !abort;
            delayed_sample <= vld[RD_LAT-1] ? rd_data : delayed_sample;
            se_cnt         <= state_nxt == START ? '0 : se_cnt + CW'(sum_en);
            tcnt           <= state == WAIT_RES && state_nxt == WAIT_RES ? tcnt + TW'(1) : '0;
            rd_ch          <= state == ISSUE && state_nxt == ISSUE ? rd_ch + CW'(1) : '0;
            rd_point       <= state_nxt == IDLE ? '0 : accept && state_nxt == START ? rd_point + PW'(1) : rd_point;
        end
    end

    // registered control and handshake outputs derived from the upcoming state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en        <= 1'b0;
            start_sum    <= 1'b0;
            done_channel <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            error        <= 1'b0;
        end else begin
            rd_en        <= state_nxt == ISSUE;
            start_sum    <= state_nxt == START;
            done_channel <= state_nxt == CLOSE;
            out_valid    <= state_nxt == OUTPUT;
            out_data     <= !abort && state == WAIT_RES && sum_valid ? sum_result : out_data;
            busy         <= state_nxt != IDLE;
            frame_done   <= timeout || (accept && rd_point == LAST_PT);
            error        <= timeout || (error && !launch);
        end
    end
endmodule
